// File: rtl/processinho_sequencer.sv
// Control unit for the processinho datapath: walks one instruction at a time
// through RegA load, RegB load, ULA execute, result wait and result capture.
module processinho_sequencer #(
  parameter int         ULA_LATENCY = 1,
  parameter logic [3:0] NOP_OPCODE  = 4'hF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] instr_op,
  input  logic [3:0] instr_a,
  input  logic [3:0] instr_b,
  output logic [3:0] operando,
  output logic       setRegA,
  output logic       setRegB,
  output logic [3:0] ula_operation,
  output logic       latch_ula,
  input  logic [7:0] ula_result,
  output logic [7:0] result,
  output logic       done,
  output logic [7:0] instr_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;

  // WAIT runs for ULA_LATENCY cycles: the counter is loaded with one less
  // and the exit happens on the cycle it reads zero.
  localparam logic [2:0] WAIT_LOAD = 3'(ULA_LATENCY - 1);

  logic [2:0] state;
  logic [2:0] wait_cnt;
  logic [3:0] op_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       is_nop;

  assign is_nop = (op_q == NOP_OPCODE);

  // NOTE: every register in this block uses non-blocking assignment so all
  // state updates see the pre-edge values, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= 3'd0;
      op_q        <= 4'd0;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      result      <= 8'd0;
      done        <= 1'b0;
      instr_count <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q  <= instr_op;
            a_q   <= instr_a;
            b_q   <= instr_b;
            state <= S_LOAD_A;
          end
        end
        S_LOAD_A: state <= S_LOAD_B;
        S_LOAD_B: state <= is_nop ? S_CAPTURE : S_EXEC;
        S_EXEC: begin
          wait_cnt <= WAIT_LOAD;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) state <= S_CAPTURE;
          else                  wait_cnt <= wait_cnt - 3'd1;
        end
        S_CAPTURE: begin
          if (!is_nop) result <= ula_result;
          done        <= 1'b1;
          instr_count <= instr_count + 8'd1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: each output gets a default before the case so no path through the
  // block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    instr_ready   = 1'b0;
    operando      = 4'd0;
    setRegA       = 1'b0;
    setRegB       = 1'b0;
    ula_operation = 4'd0;
    latch_ula     = 1'b0;
    case (state)
      S_IDLE:   instr_ready = 1'b1;
      S_LOAD_A: begin
        operando = a_q;
        setRegA  = 1'b1;
      end
      S_LOAD_B: begin
        operando = b_q;
        setRegB  = 1'b1;
      end
      S_EXEC: begin
        ula_operation = op_q;
        latch_ula     = 1'b1;
      end
      S_WAIT:    ula_operation = op_q;
      // A NOP never drove the ULA, so there is nothing to hold.
      S_CAPTURE: ula_operation = is_nop ? 4'd0 : op_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_processinho_sequencer.sv
// Directed bench for processinho_sequencer: a default-latency instance and a
// latency-3 instance, each paired with a small RegA/RegB/ULA adder model.
module tb_processinho_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- default-latency instance ----------------
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_op = 4'd0, instr_a = 4'd0, instr_b = 4'd0;
  logic [3:0] operando, ula_operation;
  logic       setRegA, setRegB, latch_ula, done;
  logic [7:0] ula_result = 8'd0, result, instr_count;

  processinho_sequencer dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_a(instr_a), .instr_b(instr_b),
    .operando(operando), .setRegA(setRegA), .setRegB(setRegB),
    .ula_operation(ula_operation), .latch_ula(latch_ula),
    .ula_result(ula_result), .result(result), .done(done),
    .instr_count(instr_count)
  );

  logic [3:0] reg_a = 4'd0, reg_b = 4'd0;
  always @(posedge clock) begin
    if (setRegA)   reg_a <= operando;
    if (setRegB)   reg_b <= operando;
    if (latch_ula) ula_result <= 8'(reg_a) + 8'(reg_b);
  end

  // ---------------- latency-3 instance ----------------
  logic       v3 = 1'b0;
  logic       rdy3;
  logic [3:0] op3 = 4'd0, a3 = 4'd0, b3 = 4'd0;
  logic [3:0] opnd3, ulaop3;
  logic       sa3, sb3, lu3, done3;
  logic [7:0] ures3 = 8'd0, res3, cnt3;

  processinho_sequencer #(.ULA_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset),
    .instr_valid(v3), .instr_ready(rdy3),
    .instr_op(op3), .instr_a(a3), .instr_b(b3),
    .operando(opnd3), .setRegA(sa3), .setRegB(sb3),
    .ula_operation(ulaop3), .latch_ula(lu3),
    .ula_result(ures3), .result(res3), .done(done3),
    .instr_count(cnt3)
  );

  logic [3:0] reg_a3 = 4'd0, reg_b3 = 4'd0;
  always @(posedge clock) begin
    if (sa3) reg_a3 <= opnd3;
    if (sb3) reg_b3 <= opnd3;
    if (lu3) ures3  <= 8'(reg_a3) + 8'(reg_b3);
  end

  // ---------------- monitors ----------------
  int mutex_err = 0;
  int latch_cnt = 0;
  always @(negedge clock) begin
    assert (32'(setRegA) + 32'(setRegB) + 32'(latch_ula) <= 1) else mutex_err++;
    assert (32'(sa3) + 32'(sb3) + 32'(lu3) <= 1) else mutex_err++;
    if (latch_ula) latch_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Issues one instruction on the default instance and waits (bounded) for done.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] exp, input string tag);
    int n;
    instr_valid = 1'b1; instr_op = op; instr_a = a; instr_b = b;
    cyc(1);
    instr_valid = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      cyc(1);
      n++;
    end
    check({tag, "_timeout"}, 32'(done), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(exp));
  endtask

  initial begin
    // Reset
    cyc(2);
    reset = 1'b0;
    cyc(1);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_ctrl", {operando, ula_operation, setRegA, setRegB, latch_ula}, 32'd0);

    // Add 9 + 7, cycle by cycle
    instr_valid = 1'b1; instr_op = 4'd0; instr_a = 4'd9; instr_b = 4'd7;
    cyc(1);
    instr_valid = 1'b0;
    check("c1_setA", {setRegA, setRegB, latch_ula}, 32'b100);
    check("c1_operando", 32'(operando), 32'd9);
    check("c1_ready", 32'(instr_ready), 32'd0);
    cyc(1);
    check("c2_setB", {setRegA, setRegB, latch_ula}, 32'b010);
    check("c2_operando", 32'(operando), 32'd7);
    cyc(1);
    check("c3_latch", {setRegA, setRegB, latch_ula}, 32'b001);
    check("c3_operando", 32'(operando), 32'd0);
    cyc(2);
    check("c5_done", 32'(done), 32'd0);
    cyc(1);
    check("c6_done", 32'(done), 32'd1);
    check("c6_result", 32'(result), 32'd16);
    check("c6_count", 32'(instr_count), 32'd1);
    check("c6_ready", 32'(instr_ready), 32'd1);
    cyc(1);
    check("c7_done_pulse", 32'(done), 32'd0);

    // NOP after result 16
    begin
      int lc;
      lc = latch_cnt;
      instr_valid = 1'b1; instr_op = 4'hF; instr_a = 4'd1; instr_b = 4'd2;
      cyc(1);
      instr_valid = 1'b0;
      check("nop_c1_setA", 32'(setRegA), 32'd1);
      cyc(1);
      check("nop_c2_setB", 32'(setRegB), 32'd1);
      cyc(1);
      check("nop_c3_done", 32'(done), 32'd0);
      cyc(1);
      check("nop_c4_done", 32'(done), 32'd1);
      check("nop_result", 32'(result), 32'd16);
      check("nop_count", 32'(instr_count), 32'd2);
      check("nop_no_latch", 32'(latch_cnt - lc), 32'd0);
    end

    // Back-to-back with instr_valid held high
    cyc(1);
    instr_valid = 1'b1; instr_op = 4'd0; instr_a = 4'd3; instr_b = 4'd2;
    cyc(1);
    instr_a = 4'd15; instr_b = 4'd15;
    cyc(5);
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_result1", 32'(result), 32'd5);
    check("b2b_ready1", 32'(instr_ready), 32'd1);
    cyc(1);
    instr_valid = 1'b0;
    check("b2b_accept2", 32'(setRegA), 32'd1);
    check("b2b_operando2", 32'(operando), 32'd15);
    cyc(5);
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_result2", 32'(result), 32'd30);
    check("b2b_count", 32'(instr_count), 32'd4);
    cyc(8);
    check("b2b_no_extra", 32'(instr_count), 32'd4);
    check("b2b_idle", 32'(instr_ready), 32'd1);

    // Latency-3 build: 8 + 8 with op 2
    v3 = 1'b1; op3 = 4'd2; a3 = 4'd8; b3 = 4'd8;
    cyc(1);
    v3 = 1'b0;
    check("l3_c1_ulaop", 32'(ulaop3), 32'd0);
    cyc(2);
    check("l3_c3_latch", 32'(lu3), 32'd1);
    check("l3_c3_ulaop", 32'(ulaop3), 32'd2);
    cyc(1);
    check("l3_c4_wait", {lu3, rdy3, done3, ulaop3}, 32'd2);
    cyc(2);
    check("l3_c6_wait", {lu3, rdy3, done3, ulaop3}, 32'd2);
    cyc(1);
    check("l3_c7_capture", {rdy3, done3, ulaop3}, 32'd2);
    cyc(1);
    check("l3_c8_done", 32'(done3), 32'd1);
    check("l3_result", 32'(res3), 32'd16);
    check("l3_c8_ulaop", 32'(ulaop3), 32'd0);

    // Reset during WAIT
    cyc(1);
    instr_valid = 1'b1; instr_op = 4'd0; instr_a = 4'd5; instr_b = 4'd6;
    cyc(1);
    instr_valid = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("wrst_ctrl", {operando, ula_operation, setRegA, setRegB, latch_ula}, 32'd0);
    check("wrst_ready", 32'(instr_ready), 32'd1);
    check("wrst_done", 32'(done), 32'd0);
    check("wrst_result", 32'(result), 32'd0);
    check("wrst_count", 32'(instr_count), 32'd0);
    cyc(1);
    check("wrst_no_done", 32'(done), 32'd0);

    // Reset together with instr_valid: not accepted
    reset = 1'b1; instr_valid = 1'b1; instr_a = 4'd4;
    cyc(1);
    reset = 1'b0; instr_valid = 1'b0;
    check("rv_no_accept", 32'(setRegA), 32'd0);
    cyc(1);
    check("rv_still_idle", {setRegA, instr_ready}, 32'b01);

    run_instr(4'd0, 4'd2, 4'd3, 8'd5, "post_rst");
    check("post_rst_count", 32'(instr_count), 32'd1);

    // 255 more instructions: instr_count wraps to 0
    for (int i = 1; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      cyc(1);
      run_instr(4'(i % 15), iv[3:0], iv[7:4], 8'(iv[3:0]) + 8'(iv[7:4]), "loop");
    end
    check("wrap_count", 32'(instr_count), 32'd0);
    check("mutex", 32'(mutex_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/processinho_sequencer.md
# processinho_sequencer

Control unit for the processinho datapath: the two 4-bit general registers (RegA, RegB) and the ULA. It accepts one instruction at a time over a valid/ready handshake. Each instruction carries an opcode and two 4-bit operands. The sequencer then drives the shared `operando` bus, the `setRegA`/`setRegB` strobes, `ula_operation` and `latch_ula` in a fixed order. It captures the 8-bit ULA result and reports completion, which replaces manual switch/key sequencing of the datapath.

## Interface
Parameters:
- `ULA_LATENCY`, default 1: cycles from the `latch_ula` pulse until `ula_result` is valid; legal range 1..7.
- `NOP_OPCODE`, default 4'hF: opcode that loads the registers but skips ULA execution.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `instr_valid`  in  1: instruction present.
- `instr_ready`  out  1: sequencer can accept an instruction.
- `instr_op`  in  4: ULA operation code.
- `instr_a`  in  4: value for RegA.
- `instr_b`  in  4: value for RegB.
- `operando`  out  4: shared operand bus to RegA/RegB.
- `setRegA`  out  1: RegA load strobe.
- `setRegB`  out  1: RegB load strobe.
- `ula_operation`  out  4: operation select to ULA.
- `latch_ula`  out  1: ULA execute strobe.
- `ula_result`  in  8: ULA output.
- `result`  out  8: last captured ULA result.
- `done`  out  1: one-cycle completion pulse.
- `instr_count`  out  8: completed instructions, modulo 256.

## Operation
- States, with every control output a Moore decode of the state register: IDLE, LOAD_A, LOAD_B, EXEC, WAIT, CAPTURE.
- Reset (sampled at a rising edge):
  - State goes to IDLE.
  - `operando`, `setRegA`, `setRegB`, `ula_operation`, `latch_ula`, `done`, `result` and `instr_count` all go to 0.
  - `instr_ready` is 1 in the first cycle after reset.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`&&`instr_ready`, latch `instr_op`/`instr_a`/`instr_b` into internal registers and go to LOAD_A.
  - Instruction inputs are ignored at all other times.
- LOAD_A: `operando`=latched A, `setRegA`=1. Go to LOAD_B.
- LOAD_B:
  - `operando`=latched B, `setRegB`=1.
  - If op==`NOP_OPCODE`, go to CAPTURE without sampling.
  - Otherwise go to EXEC.
- EXEC: `ula_operation`=op, `latch_ula`=1 for exactly one cycle. Load the wait counter with `ULA_LATENCY`-1 and go to WAIT.
- WAIT: hold `ula_operation`. Decrement the counter; when it is 0, go to CAPTURE.
- CAPTURE:
  - Hold `ula_operation`.
  - Non-NOP: `result`<=`ula_result`.
  - NOP: `result` is unchanged.
  - In both cases, on the same edge: `done`<=1, `instr_count`<=`instr_count`+1 (wraps 255->0), and go to IDLE.
- `done` is high for exactly one cycle: the first IDLE cycle after CAPTURE.
- `ula_operation` is 0 in IDLE, LOAD_A and LOAD_B. `operando` is 0 outside LOAD_A and LOAD_B.
- At most one of `setRegA`, `setRegB`, `latch_ula` is high in any cycle.

## Timing
- Let cycle 0 be the cycle with `instr_valid`&&`instr_ready` high. Then:
  - cycle 1: LOAD_A
  - cycle 2: LOAD_B
  - cycle 3: EXEC
  - cycles 4..3+`ULA_LATENCY`: WAIT
  - cycle 4+`ULA_LATENCY`: CAPTURE
  - cycle 5+`ULA_LATENCY`: `done`=1, `result` valid, `instr_ready`=1
- Default latency from acceptance to `done` is 6 cycles. A NOP is 4 cycles (CAPTURE at cycle 3, `done` at cycle 4).
- Back-to-back: a new instruction may be accepted in the same cycle that `done` is high. Peak throughput is one instruction per 5+`ULA_LATENCY` cycles.
- `instr_ready` is low from cycle 1 until the cycle `done` rises. `instr_valid` held high during busy cycles is not consumed twice.
- Reset asserted in any state (mid-instruction included) aborts the instruction. The next cycle has all outputs at their reset values with no `done` pulse. RegA/RegB contents are not the sequencer's concern.
- Reset and `instr_valid` in the same cycle: reset wins, and the instruction is not accepted.

## Test plan
- Reset, then instr op=0 (add), A=4'd9, B=4'd7, with a model ULA returning A+B one cycle after `latch_ula`. Required: `setRegA` with `operando`=9 at cycle 1; `setRegB` with `operando`=7 at cycle 2; `latch_ula` at cycle 3; `done`=1, `result`=8'd16 and `instr_count`=1 at cycle 6.
- Two instructions with `instr_valid` held high (A=3,B=2 then A=15,B=15, add). Required: second accepted exactly in the first `done` cycle; results 5 then 30; `instr_count`=2; no extra acceptance.
- op=`NOP_OPCODE`, A=1, B=2 after a prior result of 16. Required: no `latch_ula`; `done` at cycle 4; `result` stays 16; `instr_count` increments.
- `ULA_LATENCY`=3 build, add A=8, B=8. Required: WAIT lasts 3 cycles; `ula_operation` held through CAPTURE; `done` at cycle 8 with `result`=16.
- `reset` asserted during WAIT. Required: next cycle all outputs 0, `instr_ready`=1, no `done` pulse; the following instruction completes normally.
- Run 256 instructions. Required: `instr_count` wraps to 0; `setRegA`/`setRegB`/`latch_ula` are never high simultaneously (assertion).
